// File: rtl/input_debouncer_3ch_if.sv
// Bundle between the raw-input source and the 3-channel debouncer.
//   raw_1..3  : asynchronous raw levels (source -> debouncer)
//   db_1..3   : debounced levels feeding in_1..in_3 of the logic stage
//   rise_1..3 : one-cycle strobe when db_n goes 0->1
//   fall_1..3 : one-cycle strobe when db_n goes 1->0
// master = source side (drives raw), slave = debouncer side.
interface input_debouncer_3ch_if;
  logic raw_1, raw_2, raw_3;
  logic db_1, db_2, db_3;
  logic rise_1, rise_2, rise_3;
  logic fall_1, fall_2, fall_3;

  modport master (
    output raw_1, raw_2, raw_3,
    input  db_1, db_2, db_3, rise_1, rise_2, rise_3, fall_1, fall_2, fall_3
  );

  modport slave (
    input  raw_1, raw_2, raw_3,
    output db_1, db_2, db_3, rise_1, rise_2, rise_3, fall_1, fall_2, fall_3
  );
endinterface

// File: rtl/input_debouncer_3ch.sv
// Three independent input conditioners: SYNC_STAGES-deep synchroniser followed
// by a consecutive-sample debounce FSM. Outputs are registered clean levels
// plus one-cycle rise/fall strobes that coincide with the level change.
//   clk : single clock domain
//   rst : synchronous, active-high; clears sync chains, FSMs, counts, outputs
//   bus : input_debouncer_3ch_if.slave (raw_n in; db_n / rise_n / fall_n out)
module input_debouncer_3ch #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input_debouncer_3ch_if.slave  bus
);
  localparam int NUM_LANES = 3;
  localparam int CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {LO_STABLE, LO_CHECK, HI_STABLE, HI_CHECK} state_e;

  logic [NUM_LANES-1:0] raw, db, rise, fall;

  assign raw = {bus.raw_3, bus.raw_2, bus.raw_1};
  assign {bus.db_3,   bus.db_2,   bus.db_1}   = db;
  assign {bus.rise_3, bus.rise_2, bus.rise_1} = rise;
  assign {bus.fall_3, bus.fall_2, bus.fall_1} = fall;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d, rise_q, rise_d, fall_q, fall_d;

    // Plain shift chain, nothing between flops.
    always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw[i]};
    end
    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= LO_STABLE;
        cnt_q   <= '0;
        db_q    <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        db_q    <= db_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    // cnt holds the number of disagreeing samples already seen; the sample
    // that finds cnt==CNT_MAX is the DEBOUNCE_CYCLES-th and commits, so the
    // counter never passes CNT_MAX.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      db_d    = db_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
        LO_STABLE: begin
          cnt_d = '0;
          if (s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              db_d    = 1'b1;
              rise_d  = 1'b1;
              state_d = HI_STABLE;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = LO_CHECK;
            end
          end
        end
        LO_CHECK: begin
          if (!s) begin
            cnt_d   = '0;
            state_d = LO_STABLE;
          end else if (cnt_q == CNT_MAX) begin
            db_d    = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
            state_d = HI_STABLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HI_STABLE: begin
          cnt_d = '0;
          if (!s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              db_d    = 1'b0;
              fall_d  = 1'b1;
              state_d = LO_STABLE;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = HI_CHECK;
            end
          end
        end
        HI_CHECK: begin
          if (s) begin
            cnt_d   = '0;
            state_d = HI_STABLE;
          end else if (cnt_q == CNT_MAX) begin
            db_d    = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
            state_d = LO_STABLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = LO_STABLE;
      endcase
    end

    assign db[i]   = db_q;
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
  end
endmodule

// File: tb/tb_input_debouncer_3ch.sv
module tb_input_debouncer_3ch;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  logic [2:0] cur_db;
  logic [2:0] cur6;

  always #5 clk = ~clk;

  input_debouncer_3ch_if bus ();
  input_debouncer_3ch_if bus6 ();

  input_debouncer_3ch #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  input_debouncer_3ch #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed db/rise/fall=%b expected %b", tag, obs, exp);
    end
  endtask

  // Expected values are {ch3,ch2,ch1} for each of db, rise, fall.
  task automatic chk_main(input string tag, input logic [2:0] d, input logic [2:0] r,
                          input logic [2:0] f);
    chk(tag, {bus.db_3, bus.db_2, bus.db_1, bus.rise_3, bus.rise_2, bus.rise_1,
              bus.fall_3, bus.fall_2, bus.fall_1}, {d, r, f});
  endtask

  task automatic chk6(input string tag, input logic [2:0] d, input logic [2:0] r,
                      input logic [2:0] f);
    chk(tag, {bus6.db_3, bus6.db_2, bus6.db_1, bus6.rise_3, bus6.rise_2, bus6.rise_1,
              bus6.fall_3, bus6.fall_2, bus6.fall_1}, {d, r, f});
  endtask

  // Output must hold for n-1 edges, change with strobes on edge n, then settle.
  task automatic wait_change(input string tag, input logic [2:0] new_db,
                             input logic [2:0] r, input logic [2:0] f, input int n);
    for (int i = 1; i < n; i++) begin
      step();
      chk_main({tag, "_hold"}, cur_db, 3'b000, 3'b000);
    end
    step();
    chk_main({tag, "_edge"}, new_db, r, f);
    cur_db = new_db;
    step();
    chk_main({tag, "_after"}, cur_db, 3'b000, 3'b000);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk_main(tag, cur_db, 3'b000, 3'b000);
    end
  endtask

  initial begin
    cur_db = 3'b000;
    cur6   = 3'b000;
    rst = 1'b1;
    bus.raw_1 = 1'b1; bus.raw_2 = 1'b1; bus.raw_3 = 1'b1;
    bus6.raw_1 = 1'b0; bus6.raw_2 = 1'b0; bus6.raw_3 = 1'b0;

    // 1: reset with raw high, then full 6-edge latency on all channels
    step(); chk_main("reset_0", 3'b000, 3'b000, 3'b000);
    step(); chk_main("reset_1", 3'b000, 3'b000, 3'b000);
    chk6("reset_dc1", 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    wait_change("t1_rise", 3'b111, 3'b111, 3'b000, 6);

    // 2: 3-cycle glitch on channel 1 while low is rejected
    bus.raw_1 = 1'b0;
    wait_change("t2_prep", 3'b110, 3'b000, 3'b001, 6);
    bus.raw_1 = 1'b1;
    idle("t2_pulse", 3);
    bus.raw_1 = 1'b0;
    idle("t2_reject", 10);
    // count restarted from zero: a held level needs the full latency again
    bus.raw_1 = 1'b1;
    wait_change("t2_recount", 3'b111, 3'b001, 3'b000, 6);

    // 3: channel 2 falls, then chatters without effect
    bus.raw_2 = 1'b0;
    wait_change("t3_fall", 3'b101, 3'b000, 3'b010, 6);
    for (int k = 0; k < 20; k++) begin
      bus.raw_2 = (k % 2 == 0);
      idle("t3_chatter", 2);
    end
    bus.raw_2 = 1'b0;
    idle("t3_quiet", 6);

    // 4: simultaneous opposite transitions on channels 1 and 3
    bus.raw_1 = 1'b0;
    wait_change("t4_prep", 3'b100, 3'b000, 3'b001, 6);
    bus.raw_1 = 1'b1;
    bus.raw_3 = 1'b0;
    wait_change("t4_simul", 3'b001, 3'b001, 3'b100, 6);

    // 5: reset mid-count discards progress; full latency after release
    bus.raw_1 = 1'b0;
    wait_change("t5_prep", 3'b000, 3'b000, 3'b001, 6);
    bus.raw_1 = 1'b1;
    idle("t5_count", 4);
    rst = 1'b1;
    step(); chk_main("t5_rst", 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    wait_change("t5_after", 3'b001, 3'b001, 3'b000, 6);

    // 6: DEBOUNCE_CYCLES=1 instance, channel 3
    bus6.raw_3 = 1'b1;
    step(); chk6("t6_r1", cur6, 3'b000, 3'b000);
    step(); chk6("t6_r2", cur6, 3'b000, 3'b000);
    step(); chk6("t6_r3", 3'b100, 3'b100, 3'b000);
    cur6 = 3'b100;
    step(); chk6("t6_r4", cur6, 3'b000, 3'b000);
    bus6.raw_3 = 1'b0;
    step(); chk6("t6_f1", cur6, 3'b000, 3'b000);
    step(); chk6("t6_f2", cur6, 3'b000, 3'b000);
    step(); chk6("t6_f3", 3'b000, 3'b000, 3'b100);
    cur6 = 3'b000;
    step(); chk6("t6_f4", cur6, 3'b000, 3'b000);
    bus6.raw_3 = 1'b1;
    step(); chk6("t6_p1", cur6, 3'b000, 3'b000);
    bus6.raw_3 = 1'b0;
    step(); chk6("t6_p2", cur6, 3'b000, 3'b000);
    step(); chk6("t6_p3", 3'b100, 3'b100, 3'b000);
    step(); chk6("t6_p4", 3'b000, 3'b000, 3'b100);
    step(); chk6("t6_p5", 3'b000, 3'b000, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
